// File: rtl/serial_add_pkg.sv
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t       : controller state encoding (IDLE/RUN/DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : bit counter width, never less than one bit
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // max(1, clog2(w)); WIDTH=1 still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// fa_cell
// Combinational 1-bit full adder shared by the serial adder controller.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in by
// stepping one shared full-adder cell over WIDTH cycles, LSB first.
// Parameters:
//   WIDTH : operand/result width, 1..32
// Ports:
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   start           : request, sampled when ready=1
//   a, b, cin       : operands and carry-in, captured on an accepted start
//   ready           : can accept start (IDLE or DONE)
//   busy            : addition in progress (RUN)
//   done            : one-cycle pulse, sum/cout valid
//   sum, cout       : result, held until the next completion
//   ovf             : signed overflow, only when SERIAL_ADD_OVF_EN is defined
// Optional feature macro: SERIAL_ADD_OVF_EN
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             accept;
    logic             last;

    fa_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (c),
        .sum  (s),
        .cout (co)
    );

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == RUN) && (cnt == CW'(WIDTH - 1));

    // Whole-vector shift plus inserted MSB also covers WIDTH=1 without
    // a special case (the shift term is then zero).
    assign sum_sh_nxt = (sum_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
        end else if (state_q == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_sh_nxt;
            c      <= co;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum  <= sum_sh_nxt;
                cout <= co;
`ifdef SERIAL_ADD_OVF_EN
                // On the last step c is the carry into the MSB.
                ovf  <= c ^ co;
`endif
            end
        end
    end

endmodule
